// File: rtl/mux_arbiter_2_pkg.sv
// -----------------------------------------------------------------------------
// mux_arbiter_2_pkg
// Shared definitions for the two-requester round-robin arbiter:
//   - arbiter state encoding (IDLE / OWN0 / OWN1 / TURN)
//   - default hold-time and hold-counter width constants
//   - helper mapping a requester index to its ownership state
// -----------------------------------------------------------------------------
package mux_arbiter_2_pkg;

    localparam int unsigned DEFAULT_MAX_HOLD = 8;
    localparam int unsigned DEFAULT_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10,
        ST_TURN = 2'b11
    } arb_state_t;

    // Ownership state for requester 'owner' (0 -> OWN0, 1 -> OWN1).
    function automatic arb_state_t own_state(input logic owner);
        return owner ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// -----------------------------------------------------------------------------
// arb_hold_counter
// Saturating up-counter that measures how long the current owner has held
// the shared resource.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset (count -> 0)
//   clr     in   synchronous clear, has priority over en
//   en      in   count enable; counting stops once MAX is reached
//   at_max  out  high while the count equals MAX
// -----------------------------------------------------------------------------
module arb_hold_counter
    import mux_arbiter_2_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_CNT_W,
    parameter int unsigned MAX   = DEFAULT_MAX_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt;

    // Clear wins over enable; once at MAX the count sticks until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_VAL);

endmodule

// File: rtl/mux_arbiter_2.sv
// -----------------------------------------------------------------------------
// mux_arbiter_2
// Two-requester round-robin arbiter for a shared 2:1-multiplexed resource.
// Grants are registered, a one-cycle dead TURN state separates any two
// ownerships, and an owner is forcibly preempted after MAX_HOLD+1 owned
// cycles if the other side is waiting.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req0     in   request from requester 0 (mux input i0)
//   req1     in   request from requester 1 (mux input i1)
//   gnt0     out  grant to requester 0, registered
//   gnt1     out  grant to requester 1, registered
//   sel      out  mux select, registered; 0 selects i0, 1 selects i1
//   busy     out  gnt0 | gnt1
//   preempt  out  one-cycle pulse during the TURN cycle after a forced revoke
// -----------------------------------------------------------------------------
module mux_arbiter_2
    import mux_arbiter_2_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic busy,
    output logic preempt
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_owner;
    logic       last_owner_next;
    logic       preempt_next;
    logic       hold_at_max;
    logic       hold_clr;
    logic       owning;

    assign owning = (state == ST_OWN0) || (state == ST_OWN1);

    // The counter restarts from zero on every cycle that does not continue
    // the current ownership, so it reads 0 on the first owned cycle.
    assign hold_clr = !(owning && (state_next == state));

    arb_hold_counter #(
        .WIDTH (CNT_W),
        .MAX   (MAX_HOLD)
    ) u_hold_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (hold_clr),
        .en     (1'b1),
        .at_max (hold_at_max)
    );

    // Next-state logic. last_owner records who just gave up the resource so
    // that ties (in IDLE) and the TURN decision favour the other requester.
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        preempt_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_next = own_state(~last_owner);
                end else if (req0) begin
                    state_next = ST_OWN0;
                end else if (req1) begin
                    state_next = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    last_owner_next = 1'b0;
                    state_next      = req1 ? ST_TURN : ST_IDLE;
                end else if (req1 && hold_at_max) begin
                    last_owner_next = 1'b0;
                    state_next      = ST_TURN;
                    preempt_next    = 1'b1;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    last_owner_next = 1'b1;
                    state_next      = req0 ? ST_TURN : ST_IDLE;
                end else if (req0 && hold_at_max) begin
                    last_owner_next = 1'b1;
                    state_next      = ST_TURN;
                    preempt_next    = 1'b1;
                end
            end
            ST_TURN: begin
                if (last_owner ? req0 : req1) begin
                    state_next = own_state(~last_owner);
                end else if (last_owner ? req1 : req0) begin
                    state_next = own_state(last_owner);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so grant and select move on
    // the same edge as the state. sel only changes when entering an ownership
    // state, which always comes from IDLE or TURN where busy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            sel        <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            gnt0       <= (state_next == ST_OWN0);
            gnt1       <= (state_next == ST_OWN1);
            preempt    <= preempt_next;
            if (state_next == ST_OWN0) begin
                sel <= 1'b0;
            end else if (state_next == ST_OWN1) begin
                sel <= 1'b1;
            end
        end
    end

    assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_mux_arbiter_2.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter_2
// Directed testbench for mux_arbiter_2 with MAX_HOLD=4. Inputs change and
// outputs are sampled on the falling clock edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_mux_arbiter_2;

    logic clk;
    logic rst_n;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic sel;
    logic busy;
    logic preempt;

    int checks;
    int errors;

    mux_arbiter_2 #(
        .MAX_HOLD (4),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before end of tests");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bring the arbiter back to IDLE with no requests pending.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset holds everything low even with both requesting; release grants 0.
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, busy, preempt} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got gnt0,gnt1,sel,busy,preempt=%b expected 00000",
                     {gnt0, gnt1, sel, busy, preempt});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, busy, preempt} !== 5'b10010) begin
            errors++;
            $display("[TB] FAIL reset_release_grant: got gnt0,gnt1,sel,busy,preempt=%b expected 10010",
                     {gnt0, gnt1, sel, busy, preempt});
        end
    endtask

    // A lone requester keeps the grant forever with no preemption.
    task automatic test_single();
        do_reset();
        req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, busy} !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL single_grant: got gnt0,gnt1,sel,busy=%b expected 0111",
                     {gnt0, gnt1, sel, busy});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt1, sel, preempt} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL single_hold cycle %0d: got gnt1,sel,preempt=%b expected 110",
                         i, {gnt1, sel, preempt});
            end
        end
        req1 = 1'b0;
    endtask

    // Owner 0 drops its request while 1 waits: one dead cycle, then owner 1.
    task automatic test_release();
        do_reset();
        req0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL release_own0_c1: got gnt0,gnt1,sel=%b expected 100", {gnt0, gnt1, sel});
        end
        req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, preempt} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL release_own0_c2: got gnt0,gnt1,sel,preempt=%b expected 1000",
                     {gnt0, gnt1, sel, preempt});
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, busy, preempt} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL release_turn: got gnt0,gnt1,sel,busy,preempt=%b expected 00000",
                     {gnt0, gnt1, sel, busy, preempt});
        end
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, busy, preempt} !== 5'b01110) begin
            errors++;
            $display("[TB] FAIL release_own1: got gnt0,gnt1,sel,busy,preempt=%b expected 01110",
                     {gnt0, gnt1, sel, busy, preempt});
        end
        req1 = 1'b0;
    endtask

    // Both requesting: 5 owned cycles each, a preempting TURN in between.
    task automatic test_preempt();
        logic       owner;
        logic [3:0] exp;
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk);
            owner = ((cyc / 6) % 2) == 1;
            if ((cyc % 6) == 5) begin
                exp = {1'b0, 1'b0, owner, 1'b1};
            end else begin
                exp = {~owner, owner, owner, 1'b0};
            end
            checks++;
            if ({gnt0, gnt1, sel, preempt} !== exp) begin
                errors++;
                $display("[TB] FAIL preempt cycle %0d: got gnt0,gnt1,sel,preempt=%b expected %b",
                         cyc, {gnt0, gnt1, sel, preempt}, exp);
            end
            checks++;
            if ((gnt0 & gnt1) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL preempt_overlap cycle %0d: got gnt0&gnt1=%b expected 0",
                         cyc, gnt0 & gnt1);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Reset between edges clears a grant at once and restores last_owner=1.
    task automatic test_async_reset();
        do_reset();
        req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt1, sel, busy} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL async_pre_grant: got gnt1,sel,busy=%b expected 111", {gnt1, sel, busy});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, sel, busy, preempt} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL async_clear: got gnt0,gnt1,sel,busy,preempt=%b expected 00000",
                     {gnt0, gnt1, sel, busy, preempt});
        end
        req0 = 1'b1;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, busy} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL async_after_release: got gnt0,gnt1,sel,busy=%b expected 1001",
                     {gnt0, gnt1, sel, busy});
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // After requester 0 last owned, a simultaneous tie in IDLE goes to 1.
    task automatic test_tie();
        do_reset();
        req0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL tie_first_owner: got gnt0,gnt1=%b expected 10", {gnt0, gnt1});
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL tie_idle: got gnt0,gnt1,sel,busy=%b expected 0000", {gnt0, gnt1, sel, busy});
        end
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, sel, busy} !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL tie_round_robin: got gnt0,gnt1,sel,busy=%b expected 0111",
                     {gnt0, gnt1, sel, busy});
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        test_reset();
        test_single();
        test_release();
        test_preempt();
        test_async_reset();
        test_tie();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_2.md
Name: mux_arbiter_2

Overview:
Two-requester round-robin arbiter that shares one 2:1-multiplexed datapath resource, such as the accumulator/memory bus port.
- Issues a registered grant to one requester at a time.
- Drives the mux select line to match the current owner.
- Enforces a bounded hold time, with forced preemption when the other side is waiting.
- Sits between the two bus masters (e.g. fetch unit and execute unit) and the mux select input.

Parameters:
MAX_HOLD, 8, max consecutive owned cycles before preemption when the other requester waits; legal range 1..2^CNT_W-1.
CNT_W, 4, hold counter width.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  request from requester 0 (mux input i0)
req1  input  1  request from requester 1 (mux input i1)
gnt0  output  1  grant to requester 0, registered
gnt1  output  1  grant to requester 1, registered
sel  output  1  mux select, registered; 0 selects i0, 1 selects i1
busy  output  1  gnt0 | gnt1
preempt  output  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, gnt0=0, gnt1=0, sel=0, busy=0, preempt=0, hold_cnt=0, last_owner=1 (so req0 wins the first tie).
- Reset asserted mid-ownership: all outputs clear immediately; no turnaround cycle.
- States: IDLE, OWN0, OWN1, TURN.
- Grant latency: gnt rises on the first clk edge where the request is sampled high in IDLE or TURN.
  - sel updates on the same edge as gnt (OWN0: sel=0, OWN1: sel=1).
  - sel is held at its last value in IDLE and TURN.
- IDLE:
  - req0 only -> OWN0; req1 only -> OWN1.
  - Both -> grant the requester != last_owner.
  - Neither -> stay.
- OWNx:
  - hold_cnt clears on entry and increments each cycle, saturating at MAX_HOLD.
  - reqx low, other requester high -> TURN.
  - reqx low, other requester low -> IDLE.
  - reqx high, other high, hold_cnt==MAX_HOLD -> TURN with preempt=1 for that one cycle.
  - reqx high, other low -> stay indefinitely; the counter saturates with no preemption.
  - last_owner <= x on leaving OWNx.
- TURN (exactly one cycle, gnt0=gnt1=0 as a dead cycle for bus turnaround):
  - Next state is OWN of the requester != last_owner if it is requesting.
  - Else OWN of last_owner if that one is requesting.
  - Else IDLE.
- Invariants:
  - gnt0 & gnt1 is never 1.
  - sel never changes while busy=1.
  - The ownership-to-ownership handover gap is always exactly one cycle.
- A requester deasserting req without having been granted is legal; no state effect.

Decomposition:
- Shared include file arb_defs.vh holds:
  - state encodings ST_IDLE=2'b00, ST_OWN0=2'b01, ST_OWN1=2'b10, ST_TURN=2'b11;
  - default MAX_HOLD/CNT_W constants.
- One natural sub-module, arb_hold_counter: saturating counter with clear, enable and at_max flag, clocked on clk/rst_n.
- The arbiter's sel output wires directly to the existing 2:1 mux select at the integration level; the mux is not instantiated inside this block.

Test Plan:
1. Reset: hold rst_n=0 with req0=req1=1 -> all outputs 0. Release rst_n -> next edge gnt0=1, sel=0, busy=1.
2. Single requester: req1=1 from cycle 0 with req0=0 -> cycle 1 gnt1=1, sel=1. After 20 cycles still granted, preempt never pulses.
3. Voluntary release with contention (MAX_HOLD=4): owner 0, req1 raised, req0 dropped at cycle 2 of ownership -> one TURN cycle with gnt0=gnt1=0, then gnt1=1 and sel=1.
4. Preemption (MAX_HOLD=4): req0 and req1 held high continuously -> gnt0 high 5 cycles (hold_cnt 0..4), preempt=1 in the TURN cycle, then gnt1 for 5 cycles. Alternation continues with no overlapping grants.
5. Async reset mid-ownership: assert rst_n low between clock edges while gnt1=1 -> gnt1, sel and busy drop without a clock edge. After release with both requesting -> gnt0 wins (last_owner reset to 1).
6. Round-robin tie: both requests arrive simultaneously in IDLE after requester 0 last owned -> gnt1 granted first.
